// File: rtl/edit_key_controller.sv
// Button front end for the time-counter edit interface: sync/debounce four raw buttons,
// run the RUN/EDIT state machine and emit single-cycle KeyPlus/KeyMinus pulses with auto-repeat.
module edit_key_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD   = 100000,
    parameter int unsigned EDIT_TIMEOUT    = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       BtnSet,
    input  logic       BtnMode,
    input  logic       BtnPlus,
    input  logic       BtnMinus,
    output logic       EditMode,
    output logic [2:0] EditPos,
    output logic [1:0] screen,
    output logic       KeyPlus,
    output logic       KeyMinus
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam int unsigned TW = $clog2(EDIT_TIMEOUT + 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_EDIT = 1'b1;

    // Button index: 0 Set, 1 Mode, 2 Plus, 3 Minus
    logic [3:0]    raw, sync1, sync2, lvl, lvl_d, armed, ev;
    logic [DW-1:0] db_cnt [4];

    assign raw = {BtnMinus, BtnPlus, BtnMode, BtnSet};

    // Synchronisers reset to "pressed" so a button held through reset never arms until seen released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '1;
            lvl_d <= '1;
            armed <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_d <= lvl;
            armed <= armed | sync2;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        lvl[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign ev = lvl_d & ~lvl & armed;

    logic [0:0]    state;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt, rlim;
    logic          kp_d, km_d, set_pend, mode_pend;
    logic          rep_on, rep_minus, rep_phase;
    logic          allow, set_req, mode_req, apply, to_run, chg;
    logic          solo_p, solo_m, key_ok, plus_first, minus_first;
    logic          rep_alive, rep_due, do_plus, do_minus;

    assign EditMode = (state == ST_EDIT);

    always_comb begin
        allow       = KeyPlus & KeyMinus & kp_d & km_d;
        set_req     = ev[0] | set_pend;
        mode_req    = (ev[1] | mode_pend) & ~set_req;
        apply       = allow & (set_req | mode_req);
        to_run      = allow & ~set_req & ~mode_req & (state == ST_EDIT) &
                      (tcnt == TW'(EDIT_TIMEOUT - 1));
        chg         = apply | to_run;
        solo_p      = ~lvl[2] & lvl[3];
        solo_m      = lvl[2] & ~lvl[3];
        key_ok      = ~ev[0] & ~ev[1];
        plus_first  = key_ok & ev[2] & lvl[3];
        minus_first = key_ok & ~ev[2] & ev[3] & lvl[2];
        rlim        = rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
        rep_alive   = rep_on & (rep_minus ? solo_m : solo_p);
        rep_due     = rep_alive & (rcnt == rlim);
        // An interface change owns its edge: pulses due then are dropped (events) or deferred (repeat).
        do_plus     = ~chg & (plus_first | (rep_due & ~rep_minus));
        do_minus    = ~chg & ~plus_first & (minus_first | (rep_due & rep_minus));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            EditPos   <= '0;
            screen    <= '0;
            KeyPlus   <= 1'b1;
            KeyMinus  <= 1'b1;
            kp_d      <= 1'b1;
            km_d      <= 1'b1;
            set_pend  <= 1'b0;
            mode_pend <= 1'b0;
            tcnt      <= '0;
            rcnt      <= '0;
            rep_on    <= 1'b0;
            rep_minus <= 1'b0;
            rep_phase <= 1'b0;
        end else begin
            kp_d     <= KeyPlus;
            km_d     <= KeyMinus;
            KeyPlus  <= ~do_plus;
            KeyMinus <= ~do_minus;

            if ((plus_first | minus_first) & (do_plus | do_minus)) begin
                rep_on    <= 1'b1;
                rep_minus <= do_minus;
                rep_phase <= 1'b0;
                rcnt      <= '0;
            end else if (!rep_alive) begin
                rep_on <= 1'b0;
                rcnt   <= '0;
            end else if (rep_due) begin
                if (!chg) begin
                    rcnt      <= '0;
                    rep_phase <= 1'b1;
                end
            end else begin
                rcnt <= rcnt + 1'b1;
            end

            if (apply) begin
                set_pend  <= 1'b0;
                mode_pend <= 1'b0;
            end else begin
                set_pend  <= set_req;
                mode_pend <= mode_req;
            end

            if (apply & set_req) begin
                state   <= (state == ST_RUN) ? ST_EDIT : ST_RUN;
                EditPos <= '0;
                tcnt    <= '0;
            end else if (apply) begin
                if (state == ST_RUN) screen <= screen + 2'd1;
                else EditPos <= (EditPos == 3'd5) ? 3'd0 : EditPos + 3'd1;
                tcnt <= '0;
            end else if (to_run) begin
                state   <= ST_RUN;
                EditPos <= '0;
                tcnt    <= '0;
            end else if (state == ST_RUN || (|ev) || do_plus || do_minus) begin
                tcnt <= '0;
            end else if (tcnt != TW'(EDIT_TIMEOUT - 1)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_edit_key_controller.sv
// Scoreboard bench for edit_key_controller: expected pulses are queued with their cycle when
// buttons are driven and matched when KeyPlus/KeyMinus go low.
module tb_edit_key_controller;

    localparam int unsigned DEB = 4;

    logic       clk, reset;
    logic [3:0] btn;
    logic       EditMode, KeyPlus, KeyMinus;
    logic [2:0] EditPos;
    logic [1:0] screen;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0] kind;
        int         at;
    } exp_t;
    exp_t sb[$];

    localparam logic [1:0] PLUS_LOW  = 2'b01;
    localparam logic [1:0] MINUS_LOW = 2'b10;

    edit_key_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(16),
        .REPEAT_PERIOD(4),
        .EDIT_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .BtnSet(btn[0]),
        .BtnMode(btn[1]),
        .BtnPlus(btn[2]),
        .BtnMinus(btn[3]),
        .EditMode(EditMode),
        .EditPos(EditPos),
        .screen(screen),
        .KeyPlus(KeyPlus),
        .KeyMinus(KeyMinus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b0;
        tick(hold);
        btn[b] = 1'b1;
        tick(12);
    endtask

    always @(negedge clk) begin
        if (reset && (!KeyPlus || !KeyMinus)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {KeyPlus, KeyMinus}, 2'b11);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {KeyPlus, KeyMinus}, e.kind);
                chk("pulse_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int n;
        logic [1:0] exp_screen;
        logic [2:0] exp_pos;
        btn   = '1;
        reset = 1'b0;
        tick(3);
        chk("rst_mode", EditMode, 1'b0);
        chk("rst_pos", EditPos, 3'd0);
        chk("rst_screen", screen, 2'd0);
        chk("rst_keys", {KeyPlus, KeyMinus}, 2'b11);
        reset = 1'b1;
        tick(5);

        // bouncing Plus press in RUN
        for (int i = 0; i < 3; i++) begin
            btn[2] = 1'b0; tick(2);
            btn[2] = 1'b1; tick(2);
        end
        btn[2] = 1'b0;
        push(PLUS_LOW, cyc + DEB + 3);
        tick(12);
        btn[2] = 1'b1;
        tick(12);
        chk("bounce_sb", sb.size(), 0);

        exp_screen = 2'd0;
        for (int i = 0; i < 5; i++) begin
            press(1, 10);
            exp_screen = exp_screen + 2'd1;
            chk("run_screen", screen, exp_screen);
        end

        press(0, 10);
        chk("enter_edit", EditMode, 1'b1);
        chk("enter_pos", EditPos, 3'd0);

        exp_pos = 3'd0;
        for (int i = 0; i < 7; i++) begin
            press(1, 10);
            exp_pos = (exp_pos == 3'd5) ? 3'd0 : exp_pos + 3'd1;
            chk("edit_pos", EditPos, exp_pos);
            chk("edit_screen", screen, exp_screen);
        end

        // Minus held: first pulse, then +16 and every 4; released between +36 and +40
        btn[3] = 1'b0;
        n = cyc;
        push(MINUS_LOW, n + 7);
        for (int k = 0; k < 6; k++) push(MINUS_LOW, n + 23 + 4 * k);
        tick(38);
        btn[3] = 1'b1;
        tick(20);
        chk("repeat_sb", sb.size(), 0);
        chk("repeat_mode", EditMode, 1'b1);

        // timeout: 64 edges after the Mode event edge
        btn[1] = 1'b0;
        n = cyc;
        exp_pos = (exp_pos == 3'd5) ? 3'd0 : exp_pos + 3'd1;
        tick(10);
        btn[1] = 1'b1;
        chk("to_pos_step", EditPos, exp_pos);
        tick(n + 70 - cyc);
        chk("to_before", EditMode, 1'b1);
        tick(1);
        chk("to_mode", EditMode, 1'b0);
        chk("to_pos", EditPos, 3'd0);
        tick(10);

        // Mode event the cycle after a pulse is applied one cycle late
        btn[2] = 1'b0;
        n = cyc;
        push(PLUS_LOW, n + 7);
        tick(2);
        btn[1] = 1'b0;
        tick(7);
        chk("stab_hold", screen, exp_screen);
        tick(1);
        exp_screen = exp_screen + 2'd1;
        chk("stab_step", screen, exp_screen);
        btn[2] = 1'b1;
        tick(5);
        btn[1] = 1'b1;
        tick(20);
        chk("stab_sb", sb.size(), 0);

        // Set and Plus in the same cycle: Set wins, Plus discarded
        btn[0] = 1'b0;
        btn[2] = 1'b0;
        tick(30);
        chk("setplus_mode", EditMode, 1'b1);
        btn[0] = 1'b1;
        btn[2] = 1'b1;
        tick(12);

        // Plus and Minus together: no pulses
        btn[2] = 1'b0;
        btn[3] = 1'b0;
        tick(40);
        btn[2] = 1'b1;
        btn[3] = 1'b1;
        tick(10);
        chk("both_mode", EditMode, 1'b1);
        chk("both_screen", screen, exp_screen);

        // reset during a KeyPlus pulse, Plus held through release
        btn[2] = 1'b0;
        n = cyc;
        push(PLUS_LOW, n + 7);
        tick(7);
        #1 reset = 1'b0;
        #1;
        chk("midrst_key", {KeyPlus, KeyMinus}, 2'b11);
        chk("midrst_mode", EditMode, 1'b0);
        chk("midrst_screen", screen, 2'd0);
        chk("midrst_pos", EditPos, 3'd0);
        tick(3);
        reset = 1'b1;
        tick(30);
        chk("held_sb", sb.size(), 0);
        btn[2] = 1'b1;
        tick(12);
        btn[2] = 1'b0;
        push(PLUS_LOW, cyc + 7);
        tick(10);
        btn[2] = 1'b1;
        tick(12);
        chk("final_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
